// File: rtl/slave_in_port_burst.sv
// ---------------------------------------------------------------------------
// slave_in_port_burst
//
// Serial slave input port of the system bus with burst support. A request
// arrives over three LSB-first serial lines (address, write data, burst
// length). The port expands each burst into one request per beat with an
// auto-incrementing address. Beats leave through a one-entry valid/ready
// buffer. While that buffer is full, the port holds off the master one bit at
// a time. If the master stalls for too long mid-transfer, the transfer is
// aborted.
//
// Ports:
//   clk, reset_n         rising-edge clock, asynchronous active-low reset
//   master_valid         master presents a bit this cycle
//   read_en, write_en    request type, sampled only on the start handshake
//   rx_address/data/burst serial address, write data and burst length
//   slave_ready          port accepts a bit this cycle
//   out_valid/out_ready  output buffer handshake
//   out_address/data     beat address and write data (data is 0 for reads)
//   out_write, out_last  beat direction and final-beat marker
//   rx_done              pulse when the final beat is taken downstream
//   rx_err               pulse when a stalled transfer is aborted
// ---------------------------------------------------------------------------
module slave_in_port_burst #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int BURST_W = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              master_valid,
    input  logic              read_en,
    input  logic              write_en,
    input  logic              rx_address,
    input  logic              rx_data,
    input  logic              rx_burst,
    output logic              slave_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_address,
    output logic [DATA_W-1:0] out_data,
    output logic              out_write,
    output logic              out_last,
    output logic              rx_done,
    output logic              rx_err
);

    localparam int BC_W = $clog2(ADDR_W + 1);
    localparam int DC_W = $clog2(DATA_W + 1);
    localparam int TC_W = $clog2(TIMEOUT + 1);

    localparam logic [BC_W-1:0] HDR_LAST  = BC_W'(ADDR_W - 1);
    localparam logic [BC_W-1:0] BURST_LIM = BC_W'(BURST_W);
    localparam logic [DC_W-1:0] DATA_LAST = DC_W'(DATA_W - 1);
    localparam logic [TC_W-1:0] TO_LAST   = TC_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HDR    = 2'd1;
    localparam logic [1:0] S_WDATA  = 2'd2;
    localparam logic [1:0] S_RISSUE = 2'd3;

    // Transfer state
    logic [1:0]         r_state;
    logic               r_write;
    logic [BC_W-1:0]    r_bitCnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] r_beatCnt;
    logic [DATA_W-1:0]  r_data;
    logic [DC_W-1:0]    r_dataCnt;
    logic [TC_W-1:0]    r_toCnt;
    logic               r_err;

    // Output buffer
    logic               r_outValid;
    logic [ADDR_W-1:0]  r_outAddr;
    logic [DATA_W-1:0]  r_outData;
    logic               r_outWrite;
    logic               r_outLast;

    // Combinational helpers
    logic               w_bufFree;
    logic               w_slaveReady;
    logic               w_accept;
    logic               w_handshake;
    logic               w_hdrBit;
    logic               w_hdrLast;
    logic               w_modeWrite;
    logic [ADDR_W-1:0]  w_addrShift;
    logic [BURST_W-1:0] w_burstShift;
    logic [BURST_W-1:0] w_burstKeep;
    logic [DATA_W-1:0]  w_dataShift;
    logic               w_dataLastBit;
    logic               w_readFirst;
    logic               w_issue;
    logic [ADDR_W-1:0]  w_curAddr;
    logic [BURST_W-1:0] w_curCnt;
    logic               w_issueLast;
    logic               w_timeout;

    // Next-state values
    logic [1:0]         w_stateNxt;
    logic               w_writeNxt;
    logic [BC_W-1:0]    w_bitCntNxt;
    logic [ADDR_W-1:0]  w_addrNxt;
    logic [BURST_W-1:0] w_burstNxt;
    logic [BURST_W-1:0] w_beatCntNxt;
    logic [DATA_W-1:0]  w_dataNxt;
    logic [DC_W-1:0]    w_dataCntNxt;
    logic [TC_W-1:0]    w_toCntNxt;

    // The buffer can take a new beat when it is empty or is being drained
    // this very cycle. In WDATA this gates slave_ready, so a finished data
    // word can always land in the buffer.
    always_comb begin
        w_bufFree = !r_outValid || out_ready;
        case (r_state)
            S_IDLE, S_HDR: w_slaveReady = 1'b1;
            S_WDATA:       w_slaveReady = w_bufFree;
            default:       w_slaveReady = 1'b0;
        endcase
    end

    // Bit acceptance and header decode. The handshake cycle already carries
    // header bit 0, so IDLE and HDR share the same shift path. Address and
    // data shift in from the top, which leaves LSB-first streams in place.
    always_comb begin
        w_accept      = master_valid && w_slaveReady;
        w_handshake   = (r_state == S_IDLE) && w_accept && (read_en ^ write_en);
        w_hdrBit      = w_handshake || ((r_state == S_HDR) && w_accept);
        w_hdrLast     = w_hdrBit && (r_bitCnt == HDR_LAST);
        w_modeWrite   = (r_state == S_IDLE) ? write_en : r_write;
        w_addrShift   = ADDR_W'({rx_address, r_addr} >> 1);
        w_burstShift  = BURST_W'({rx_burst, r_burst} >> 1);
        w_burstKeep   = (r_bitCnt < BURST_LIM) ? w_burstShift : r_burst;
        w_dataShift   = DATA_W'({rx_data, r_data} >> 1);
        w_dataLastBit = (r_state == S_WDATA) && w_accept && (r_dataCnt == DATA_LAST);
        w_timeout     = ((r_state == S_HDR) || (r_state == S_WDATA)) && !master_valid
                        && (r_toCnt == TO_LAST);
    end

    // Beat issue. A read issues its first beat on the same edge as the last
    // address bit when the buffer allows it, so the first read beat shows up
    // right after the header. The address and remaining count for that beat
    // come from the values being completed on this edge.
    always_comb begin
        w_readFirst = w_hdrLast && !w_modeWrite && w_bufFree;
        w_issue     = w_dataLastBit || w_readFirst || ((r_state == S_RISSUE) && w_bufFree);
        w_curAddr   = w_hdrLast ? w_addrShift : r_addr;
        w_curCnt    = w_hdrLast ? w_burstKeep : r_beatCnt;
        w_issueLast = (w_curCnt == '0);
    end

    // Transfer sequencing. Later assignments take priority. A beat issue
    // overrides the header-exit target when the burst is done. A timeout
    // overrides everything, because it can only happen in a cycle with no
    // accepted bit.
    always_comb begin
        w_stateNxt   = r_state;
        w_writeNxt   = r_write;
        w_bitCntNxt  = r_bitCnt;
        w_addrNxt    = r_addr;
        w_burstNxt   = r_burst;
        w_beatCntNxt = r_beatCnt;
        w_dataNxt    = r_data;
        w_dataCntNxt = r_dataCnt;
        w_toCntNxt   = '0;

        if ((r_state == S_HDR) || (r_state == S_WDATA)) begin
            w_toCntNxt = master_valid ? '0 : (r_toCnt + TC_W'(1));
        end

        if (w_handshake) begin
            w_writeNxt = write_en;
        end

        if (w_hdrBit) begin
            w_addrNxt   = w_addrShift;
            w_burstNxt  = w_burstKeep;
            w_bitCntNxt = r_bitCnt + BC_W'(1);
            w_stateNxt  = S_HDR;
        end

        if (w_hdrLast) begin
            w_bitCntNxt  = '0;
            w_beatCntNxt = w_burstKeep;
            w_stateNxt   = w_modeWrite ? S_WDATA : S_RISSUE;
        end

        if ((r_state == S_WDATA) && w_accept) begin
            w_dataNxt    = w_dataShift;
            w_dataCntNxt = r_dataCnt + DC_W'(1);
        end

        if (w_dataLastBit) begin
            w_dataCntNxt = '0;
        end

        if (w_issue) begin
            if (w_issueLast) begin
                w_stateNxt = S_IDLE;
            end else begin
                w_beatCntNxt = w_curCnt - BURST_W'(1);
                w_addrNxt    = w_curAddr + ADDR_W'(1);
            end
        end

        if (w_timeout) begin
            w_stateNxt   = S_IDLE;
            w_bitCntNxt  = '0;
            w_dataCntNxt = '0;
            w_toCntNxt   = '0;
        end
    end

    // Transfer state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_bitCnt  <= '0;
            r_addr    <= '0;
            r_burst   <= '0;
            r_beatCnt <= '0;
            r_data    <= '0;
            r_dataCnt <= '0;
            r_toCnt   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_stateNxt;
            r_write   <= w_writeNxt;
            r_bitCnt  <= w_bitCntNxt;
            r_addr    <= w_addrNxt;
            r_burst   <= w_burstNxt;
            r_beatCnt <= w_beatCntNxt;
            r_data    <= w_dataNxt;
            r_dataCnt <= w_dataCntNxt;
            r_toCnt   <= w_toCntNxt;
            r_err     <= w_timeout;
        end
    end

    // Output buffer. A load in the same cycle as a drain simply replaces the
    // entry. Fields are left untouched after a drain. A timeout does not
    // touch a beat that is already buffered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outValid <= 1'b0;
            r_outAddr  <= '0;
            r_outData  <= '0;
            r_outWrite <= 1'b0;
            r_outLast  <= 1'b0;
        end else if (w_issue) begin
            r_outValid <= 1'b1;
            r_outAddr  <= w_curAddr;
            r_outData  <= w_dataLastBit ? w_dataShift : '0;
            r_outWrite <= w_dataLastBit;
            r_outLast  <= w_issueLast;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign slave_ready = w_slaveReady;
    assign out_valid   = r_outValid;
    assign out_address = r_outAddr;
    assign out_data    = r_outData;
    assign out_write   = r_outWrite;
    assign out_last    = r_outLast;
    assign rx_done     = r_outValid && out_ready && r_outLast;
    assign rx_err      = r_err;

endmodule
